// File: rtl/serial_word_capture_if.sv
// Valid/ready word handshake between serial_word_capture and the next stage.
interface serial_word_capture_if #(
  parameter int unsigned WORD_W = 8
) ();
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/serial_word_capture.sv
// Sync-pattern hunter and MSB-first deserializer feeding a small output FIFO.
// Optional per-word even-parity check: define SERIAL_WORD_CAPTURE_PARITY_CHECK_EN.
module serial_word_capture #(
  parameter int unsigned       WORD_W       = 8,
  parameter int unsigned       SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int unsigned       FRAME_WORDS  = 4,
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   resync,
  serial_word_capture_if.master  out_if,
  output logic                   locked,
  output logic [CNT_W-1:0]       overflow_cnt,
  output logic [CNT_W-1:0]       parity_err_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
  localparam int unsigned BitsPerWord = WORD_W + 1;
`else
  localparam int unsigned BitsPerWord = WORD_W;
`endif
  localparam int unsigned BCW = $clog2(BitsPerWord + 1);
  localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [0:0] {StHunt, StCapture} state_e;

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] sync_q, sync_d, sync_shift;
  logic [WORD_W-1:0] word_sr_q, word_sr_d, word_shift, push_word;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic              push, word_done;

  assign sync_shift = SYNC_W'({sync_q, bit_in});
  assign word_shift = WORD_W'({word_sr_q, bit_in});

`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
  logic             parity_bad;
  logic [CNT_W-1:0] perr_q;
`endif

  always_comb begin
    state_d    = state_q;
    sync_d     = sync_q;
    word_sr_d  = word_sr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    push       = 1'b0;
    push_word  = word_sr_q;
    word_done  = 1'b0;
`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
    parity_bad = 1'b0;
`endif
    if (resync) begin
      // Partial word is abandoned by clearing the bit counter; FIFO untouched.
      state_d    = StHunt;
      sync_d     = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (bit_valid) begin
      case (state_q)
        StHunt: begin
          sync_d = sync_shift;
          if (sync_shift == SYNC_PATTERN) begin
            state_d    = StCapture;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
        StCapture: begin
`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
          if (bit_cnt_q == BCW'(WORD_W)) begin
            word_done = 1'b1;
            if (^{word_sr_q, bit_in}) parity_bad = 1'b1;
            else                      push       = 1'b1;
          end else begin
            word_sr_d = word_shift;
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
`else
          word_sr_d = word_shift;
          push_word = word_shift;
          if (bit_cnt_q == BCW'(WORD_W - 1)) begin
            word_done = 1'b1;
            push      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
`endif
          if (word_done) begin
            bit_cnt_d = '0;
            if (word_cnt_q == WCW'(FRAME_WORDS - 1)) begin
              state_d    = StHunt;
              sync_d     = '0;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + WCW'(1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StHunt;
      sync_q     <= '0;
      word_sr_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      word_sr_q  <= word_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign locked = (state_q == StCapture);

  // Output FIFO; the extra pointer bit separates full from empty.
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              empty, full, pop, push_ok, drop;
  logic [CNT_W-1:0]  ovf_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && out_if.word_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
    end else begin
      if (push_ok)                 wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)                     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (drop && (ovf_q != '1))   ovf_q    <= ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

  assign out_if.word_valid = !empty;
  assign out_if.word_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_cnt      = ovf_q;

`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         perr_q <= '0;
    else if (parity_bad && (perr_q != '1)) perr_q <= perr_q + CNT_W'(1);
  end
  assign parity_err_cnt = perr_q;
`else
  assign parity_err_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_word_capture.sv
// Self-checking bench for serial_word_capture: frame table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_serial_word_capture;

  logic clk = 1'b0;
  logic reset_n, bit_in, bit_valid, resync, locked;
  logic [7:0] overflow_cnt, parity_err_cnt;

  serial_word_capture_if #(.WORD_W(8)) wif ();

  serial_word_capture dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bit_in         (bit_in),
    .bit_valid      (bit_valid),
    .resync         (resync),
    .out_if         (wif),
    .locked         (locked),
    .overflow_cnt   (overflow_cnt),
    .parity_err_cnt (parity_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: stream-level view of the spec.
  bit         m_lock;
  int         m_hist, m_bits, m_cur, m_words, m_ovf, m_perr;
  logic [7:0] m_q[$];
  logic [7:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_hist = 0; m_bits = 0; m_cur = 0; m_words = 0; m_ovf = 0; m_perr = 0;
    m_q.delete();
  endtask

  task automatic model_update(input logic bv, input logic b, input logic rs, input logic rdy);
    bit pop, push, done;
    logic [7:0] pw;
    pop = (m_q.size() > 0) && rdy;
    push = 0; done = 0; pw = '0;
    if (rs) begin
      m_lock = 0; m_hist = 0; m_bits = 0; m_cur = 0; m_words = 0;
    end else if (bv) begin
      if (!m_lock) begin
        m_hist = ((m_hist << 1) | int'(b)) & 'hFF;
        if (m_hist == 'hA5) begin
          m_lock = 1; m_bits = 0; m_cur = 0; m_words = 0;
        end
      end else begin
`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
        if (m_bits < 8) begin
          m_cur = m_cur * 2 + int'(b); m_bits++;
        end else begin
          done = 1; pw = m_cur[7:0];
          if ((($countones(pw) + int'(b)) % 2) == 0) push = 1;
          else if (m_perr < 255) m_perr++;
        end
`else
        m_cur = m_cur * 2 + int'(b); m_bits++;
        if (m_bits == 8) begin done = 1; push = 1; pw = m_cur[7:0]; end
`endif
        if (done) begin
          m_bits = 0; m_cur = 0; m_words++;
          if (m_words == 4) begin m_lock = 0; m_hist = 0; end
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 4) m_q.push_back(pw);
      else if (m_ovf < 255) m_ovf++;
    end
  endtask

  task automatic compare();
    chk("valid", 32'(wif.word_valid), 32'(m_q.size() > 0));
    chk("data", 32'(wif.word_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    chk("locked", 32'(locked), 32'(m_lock));
    chk("ovf_cnt", 32'(overflow_cnt), 32'(m_ovf));
    chk("perr_cnt", 32'(parity_err_cnt), 32'(m_perr));
  endtask

  task automatic step(input logic bv, input logic b, input logic rs, input logic rdy);
    bit_valid = bv; bit_in = b; resync = rs; wif.word_ready = rdy;
    if (wif.word_valid && rdy) got.push_back(wif.word_data);
    model_update(bv, b, rs, rdy);
    @(posedge clk); #1;
    compare();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bit_valid = 0; bit_in = 0; resync = 0; wif.word_ready = 0;
    #2;
    model_reset();
    chk("rst_valid", 32'(wif.word_valid), 0);
    chk("rst_data", 32'(wif.word_data), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ovf", 32'(overflow_cnt), 0);
    chk("rst_perr", 32'(parity_err_cnt), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gap, input logic rdy);
    for (int i = 7; i >= 0; i--) begin
      if (gap) step(1'b0, 1'($urandom), 1'b0, rdy);
      step(1'b1, v[i], 1'b0, rdy);
    end
  endtask

  task automatic send_word(input logic [7:0] v, input bit gap, input logic rdy, input bit corrupt);
    send_byte(v, gap, rdy);
`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
    if (gap) step(1'b0, 1'($urandom), 1'b0, rdy);
    step(1'b1, (^v) ^ corrupt, 1'b0, rdy);
`else
    if (corrupt) step(1'b0, 1'b0, 1'b0, rdy);
`endif
  endtask

  task automatic send_frame(input logic [31:0] w, input bit gap, input logic rdy);
    send_byte(8'hA5, gap, rdy);
    for (int k = 3; k >= 0; k--) send_word(w[8*k +: 8], gap, rdy, 1'b0);
  endtask

  typedef struct {
    logic [31:0] words;
    bit          gap;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hd;
    bit hold;
    int ovf_before;

    vecs[0] = '{words: 32'h3CF00180, gap: 1'b0};
    vecs[1] = '{words: 32'h3CF00180, gap: 1'b1};
    vecs[2] = '{words: 32'hFF00AA55, gap: 1'b0};
    vecs[3] = '{words: 32'h12345678, gap: 1'b1};

    model_reset();
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Table of frames, consumer always ready.
    foreach (vecs[v]) begin
      got.delete();
      send_frame(vecs[v].words, vecs[v].gap, 1'b1);
      chk("tbl_unlock", 32'(locked), 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("tbl_count", got.size(), 4);
      for (int k = 0; k < got.size() && k < 4; k++)
        chk("tbl_word", 32'(got[k]), 32'(vecs[v].words[8*(3-k) +: 8]));
    end

    // Latency: valid rises right after the edge that takes the last bit.
    do_reset();
    send_byte(8'hA5, 1'b0, 1'b0);
    for (int i = 7; i >= 1; i--) step(1'b1, 1'(8'h3C >> i), 1'b0, 1'b0);
`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lat_pre", 32'(wif.word_valid), 0);
    step(1'b1, ^8'h3C, 1'b0, 1'b0);
`else
    chk("lat_pre", 32'(wif.word_valid), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
`endif
    chk("lat_valid", 32'(wif.word_valid), 1);
    chk("lat_data", 32'(wif.word_data), 32'h3C);

    // Backpressure over two frames, then a stalling drain.
    do_reset();
    got.delete();
    send_frame(32'h3CF00180, 1'b0, 1'b0);
    send_frame(32'h11223344, 1'b0, 1'b0);
    chk("bp_ovf", 32'(overflow_cnt), 4);
    hold = 0; hd = '0;
    for (int i = 0; i < 24; i++) begin
      logic r;
      r = 1'($urandom_range(0, 2) == 0);
      hold = wif.word_valid && !r;
      hd = wif.word_data;
      step(1'b0, 1'b0, 1'b0, r);
      if (hold) chk("bp_stable", 32'(wif.word_data), 32'(hd));
    end
    while (wif.word_valid && got.size() < 8) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_count", got.size(), 4);
    for (int k = 0; k < got.size() && k < 4; k++)
      chk("bp_word", 32'(got[k]), 32'(32'h3CF00180 >> (8*(3-k))) & 32'hFF);

    // Full FIFO with a pop on the same edge as a push: accepted, no drop.
    send_frame(32'hDEADBEEF, 1'b0, 1'b0);
    ovf_before = int'(overflow_cnt);
    send_byte(8'hA5, 1'b0, 1'b0);
    for (int i = 7; i >= 1; i--) step(1'b1, 1'(8'h5A >> i), 1'b0, 1'b0);
`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, ^8'h5A, 1'b0, 1'b1);
`else
    step(1'b1, 1'b0, 1'b0, 1'b1);
`endif
    chk("fullpop_ovf", 32'(overflow_cnt), 32'(ovf_before));
    chk("fullpop_head", 32'(wif.word_data), 32'hAD);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    // resync mid-word: nothing pushed, unlocked, relock on fresh sync.
    do_reset();
    send_byte(8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("resync_unlock", 32'(locked), 0);
    chk("resync_nopush", 32'(wif.word_valid), 0);
    got.delete();
    send_frame(32'hC0FFEE01, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resync_relock_cnt", got.size(), 4);

    // Reset mid-word, then bits that are not a sync pattern.
    send_byte(8'hA5, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    send_byte(8'h3C, 1'b0, 1'b1);
    chk("rst_mid_unlock", 32'(locked), 0);

`ifdef SERIAL_WORD_CAPTURE_PARITY_CHECK_EN
    // Parity: good word accepted, bad word dropped but still counted in frame.
    do_reset();
    got.delete();
    send_byte(8'hA5, 1'b0, 1'b1);
    send_word(8'h07, 1'b0, 1'b1, 1'b0);
    send_word(8'h07, 1'b0, 1'b1, 1'b1);
    send_word(8'h07, 1'b0, 1'b1, 1'b0);
    send_word(8'h07, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("par_perr", 32'(parity_err_cnt), 1);
    chk("par_unlock", 32'(locked), 0);
    chk("par_count", got.size(), 3);
`endif

    // Overflow counter saturates.
    do_reset();
    for (int f = 0; f < 66; f++) send_frame(32'(f), 1'b0, 1'b0);
    chk("ovf_sat", 32'(overflow_cnt), 255);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 8)
        send_byte(8'hA5, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7));
      else
        step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
